// File: rtl/dac_spi_pkg.sv
`default_nettype none
// dac_spi_pkg: shared types and frame constants for the threshold-DAC SPI writer.
// Rev 1.0
package dac_spi_pkg;

    localparam int DATA_W       = 16;
    localparam int CMD_W        = 8;
    localparam int FRAME_W      = CMD_W + DATA_W;
    localparam int HALF_PERIODS = 2 * FRAME_W;

    localparam logic [CMD_W-1:0] DEFAULT_CMD = 8'h30;

    typedef enum logic [4:0] {
        IDLE     = 5'b00001,
        CS_SETUP = 5'b00010,
        SHIFT    = 5'b00100,
        CS_HOLD  = 5'b01000,
        LOAD     = 5'b10000
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dac_spi_writer_tick_gen.sv
`default_nettype none
// spi_tick_gen: CLK_DIV down-counter giving a one-cycle tick every CLK_DIV enabled cycles.
// Rev 1.0
module spi_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            count <= '0;
        end else if (clear || !enable || (count == '0)) begin
            count <= RELOAD;
        end else begin
            count <= count - CNT_W'(1);
        end
    end

    assign tick = enable && !clear && (count == '0);

endmodule
`default_nettype wire

// File: rtl/dac_spi_writer.sv
`default_nettype none
// dac_spi_writer: accepts a 16-bit threshold write, shifts {CMD, code} to an SPI DAC
// (mode 0, MSB first), pulses LDAC, then reports ready again. Rev 1.0
module dac_spi_writer
    import dac_spi_pkg::*;
#(
    parameter int               CLK_DIV = 2,
    parameter logic [CMD_W-1:0] CMD     = DEFAULT_CMD,
    parameter int               LDAC_W  = 2
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              wre_i,
    output logic              rdy_o,
    output logic              sclk_o,
    output logic              cs_n_o,
    output logic              mosi_o,
    output logic              ldac_n_o
);

    localparam int LCNT_W = (LDAC_W > 1) ? $clog2(LDAC_W) : 1;
    localparam logic [5:0] LAST_HP = 6'(HALF_PERIODS - 1);

    state_t              state, state_n;
    logic [FRAME_W-1:0]  sr, sr_n;
    logic [5:0]          hp, hp_n;
    logic [LCNT_W-1:0]   lcnt, lcnt_n;
    logic                rdy_n, sclk_n, cs_n_n, mosi_n, ldac_n_n;
    logic                tick;
    logic [FRAME_W-1:0]  frame;

    assign frame = {CMD, data_i};

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .enable (state == CS_SETUP || state == SHIFT || state == CS_HOLD),
        .clear  (state == IDLE),
        .tick   (tick)
    );

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state    <= IDLE;
            sr       <= '0;
            hp       <= '0;
            lcnt     <= '0;
            rdy_o    <= 1'b1;
            sclk_o   <= 1'b0;
            cs_n_o   <= 1'b1;
            mosi_o   <= 1'b0;
            ldac_n_o <= 1'b1;
        end else begin
            state    <= state_n;
            sr       <= sr_n;
            hp       <= hp_n;
            lcnt     <= lcnt_n;
            rdy_o    <= rdy_n;
            sclk_o   <= sclk_n;
            cs_n_o   <= cs_n_n;
            mosi_o   <= mosi_n;
            ldac_n_o <= ldac_n_n;
        end
    end

    always_comb begin
        state_n  = state;
        sr_n     = sr;
        hp_n     = hp;
        lcnt_n   = lcnt;
        rdy_n    = rdy_o;
        sclk_n   = sclk_o;
        cs_n_n   = cs_n_o;
        mosi_n   = mosi_o;
        ldac_n_n = ldac_n_o;

        case (state)
            IDLE: begin
                if (wre_i) begin
                    mosi_n  = frame[FRAME_W-1];
                    sr_n    = {frame[FRAME_W-2:0], 1'b0};
                    rdy_n   = 1'b0;
                    cs_n_n  = 1'b0;
                    hp_n    = '0;
                    state_n = CS_SETUP;
                end
            end
            CS_SETUP: begin
                // The end of setup is also the first rising SCLK edge.
                if (tick) begin
                    sclk_n  = 1'b1;
                    hp_n    = 6'd1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (hp == LAST_HP) begin
                        sclk_n  = 1'b0;
                        mosi_n  = 1'b0;
                        hp_n    = '0;
                        state_n = CS_HOLD;
                    end else begin
                        sclk_n = ~sclk_o;
                        hp_n   = hp + 6'd1;
                        if (sclk_o) begin
                            mosi_n = sr[FRAME_W-1];
                            sr_n   = {sr[FRAME_W-2:0], 1'b0};
                        end
                    end
                end
            end
            CS_HOLD: begin
                if (tick) begin
                    cs_n_n = 1'b1;
                    if (LDAC_W > 0) begin
                        ldac_n_n = 1'b0;
                        lcnt_n   = LCNT_W'(LDAC_W - 1);
                        state_n  = LOAD;
                    end else begin
                        rdy_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            LOAD: begin
                if (lcnt == '0) begin
                    ldac_n_n = 1'b1;
                    rdy_n    = 1'b1;
                    state_n  = IDLE;
                end else begin
                    lcnt_n = lcnt - LCNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_writer.sv
`default_nettype none
// tb_dac_spi_writer: two DAC writer instances (default and CLK_DIV=1/LDAC_W=0) checked
// cycle by cycle against an edge-arithmetic model and an SPI slave capture.
module tb_dac_spi_writer;

    logic        clk  = 1'b0;
    logic        arst = 1'b1;
    logic [15:0] data_a = '0, data_b = '0;
    logic        wre_a = 1'b0, wre_b = 1'b0;
    logic [1:0]  rdy, sclk, cs_n, mosi, ldac_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dac_spi_writer #(.CLK_DIV(2), .CMD(8'h30), .LDAC_W(2)) dut_a (
        .clk_i(clk), .arst_i(arst), .data_i(data_a), .wre_i(wre_a),
        .rdy_o(rdy[0]), .sclk_o(sclk[0]), .cs_n_o(cs_n[0]), .mosi_o(mosi[0]), .ldac_n_o(ldac_n[0])
    );

    dac_spi_writer #(.CLK_DIV(1), .CMD(8'h30), .LDAC_W(0)) dut_b (
        .clk_i(clk), .arst_i(arst), .data_i(data_b), .wre_i(wre_b),
        .rdy_o(rdy[1]), .sclk_o(sclk[1]), .cs_n_o(cs_n[1]), .mosi_o(mosi[1]), .ldac_n_o(ldac_n[1])
    );

    // SPI slave models: shift MOSI on rising SCLK while selected, record frame on deselect.
    logic [23:0] sh0, sh1;
    int          cnt0 = 0, cnt1 = 0, win0 = 0, win1 = 0;
    logic        pcs0 = 1'b1, pcs1 = 1'b1, psc0 = 1'b0, psc1 = 1'b0;
    logic [23:0] capf0[$], capf1[$];
    int          capn0[$], capn1[$];

    always @(sclk[0], cs_n[0]) begin
        if (pcs0 === 1'b1 && cs_n[0] === 1'b0) begin sh0 = '0; cnt0 = 0; win0++; end
        if (psc0 !== 1'b1 && sclk[0] === 1'b1 && cs_n[0] === 1'b0) begin
            sh0 = {sh0[22:0], mosi[0]}; cnt0++;
        end
        if (pcs0 === 1'b0 && cs_n[0] === 1'b1 && arst) begin capf0.push_back(sh0); capn0.push_back(cnt0); end
        pcs0 = cs_n[0]; psc0 = sclk[0];
    end

    always @(sclk[1], cs_n[1]) begin
        if (pcs1 === 1'b1 && cs_n[1] === 1'b0) begin sh1 = '0; cnt1 = 0; win1++; end
        if (psc1 !== 1'b1 && sclk[1] === 1'b1 && cs_n[1] === 1'b0) begin
            sh1 = {sh1[22:0], mosi[1]}; cnt1++;
        end
        if (pcs1 === 1'b0 && cs_n[1] === 1'b1 && arst) begin capf1.push_back(sh1); capn1.push_back(cnt1); end
        pcs1 = cs_n[1]; psc1 = sclk[1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] outs(input int sel);
        return {rdy[sel], cs_n[sel], sclk[sel], mosi[sel], ldac_n[sel]};
    endfunction

    task automatic drive(input int sel, input logic w, input logic [15:0] d);
        if (sel == 0) begin wre_a = w; data_a = d; end
        else          begin wre_b = w; data_b = d; end
    endtask

    // Caller is #1 after a clock edge (edge 0); write strobe is driven here and sampled at edge 1.
    task automatic run_frame(input int sel, input logic [15:0] d, input int inject_at, input int abort_at);
        int D, LW, hold_e, end_e, t, falls, w_start, nbits;
        logic [23:0] f, got;
        logic [4:0]  exp;
        D      = (sel == 0) ? 2 : 1;
        LW     = (sel == 0) ? 2 : 0;
        f      = {8'h30, d};
        hold_e = 49 * D + 1;
        end_e  = hold_e + LW;
        w_start = (sel == 0) ? win0 : win1;
        check($sformatf("rdy_before_write%0d", sel), {31'd0, rdy[sel]}, 32'd1);
        drive(sel, 1'b1, d);
        for (int n = 1; n <= end_e; n++) begin
            @(posedge clk); #1;
            t     = (n < D + 1) ? 0 : (((n - D - 1) / D + 1) > 48 ? 48 : ((n - D - 1) / D + 1));
            falls = t / 2;
            exp[1] = (falls == 0) ? f[23] : ((falls < 24) ? f[23 - falls] : 1'b0);
            exp[2] = t[0];
            exp[3] = (n >= hold_e);
            exp[0] = !(LW > 0 && n >= hold_e && n < end_e);
            exp[4] = (n >= end_e);
            check($sformatf("dut%0d_edge%0d", sel, n), {27'd0, outs(sel)}, {27'd0, exp});
            if (n == 1) drive(sel, 1'b0, 16'($urandom));
            if (inject_at > 0 && n == inject_at)          drive(sel, 1'b1, 16'h1234);
            else if (inject_at > 0 && n == inject_at + 1) drive(sel, 1'b0, 16'h1234);
            if (n == abort_at) begin
                arst = 1'b0; #1;
                check("abort_async_a", {27'd0, outs(0)}, 32'h19);
                check("abort_async_b", {27'd0, outs(1)}, 32'h19);
                @(posedge clk); #1;
                check("abort_held", {27'd0, outs(sel)}, 32'h19);
                arst = 1'b1;
                return;
            end
        end
        if (sel == 0) begin
            check("frames_captured0", capf0.size(), 1);
            got = (capf0.size() > 0) ? capf0.pop_front() : 24'hx;
            nbits = (capn0.size() > 0) ? capn0.pop_front() : -1;
            check("cs_windows0", win0 - w_start, 1);
        end else begin
            check("frames_captured1", capf1.size(), 1);
            got = (capf1.size() > 0) ? capf1.pop_front() : 24'hx;
            nbits = (capn1.size() > 0) ? capn1.pop_front() : -1;
            check("cs_windows1", win1 - w_start, 1);
        end
        check($sformatf("frame%0d", sel), {8'd0, got}, {8'd0, f});
        check($sformatf("sclk_rises%0d", sel), nbits, 24);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            check("idle_a", {27'd0, outs(0)}, 32'h19);
            check("idle_b", {27'd0, outs(1)}, 32'h19);
        end
    endtask

    initial begin
        int sel, gap;
        #1 arst = 1'b0;
        #1;
        check("reset_a", {27'd0, outs(0)}, 32'h19);
        check("reset_b", {27'd0, outs(1)}, 32'h19);
        repeat (3) @(posedge clk);
        #1 arst = 1'b1;
        idle(10);

        run_frame(0, 16'hA5C3, 0, 0);
        idle(3);
        run_frame(1, 16'hFFFF, 0, 0);
        idle(2);
        run_frame(0, 16'($urandom), 20, 0);
        idle(2);
        run_frame(0, 16'h0001, 0, 0);
        run_frame(0, 16'h8000, 0, 0);
        run_frame(1, 16'h0001, 0, 0);
        run_frame(1, 16'h8000, 0, 0);
        idle(2);
        run_frame(0, 16'($urandom), 0, 40);
        run_frame(0, 16'($urandom), 0, 0);
        run_frame(1, 16'($urandom), 0, 20);
        idle(1);
        run_frame(1, 16'($urandom), 0, 0);

        for (int k = 0; k < 8; k++) begin
            sel = int'($urandom_range(1, 0));
            gap = int'($urandom_range(3, 0));
            if (gap > 0) idle(gap);
            run_frame(sel, 16'($urandom), (k % 3 == 0) ? int'($urandom_range(45, 2)) : 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
